// File: rtl/block_mac_2x2.sv
// 2x2 block multiply-accumulate responder for the matrix multiplier control unit.
// One shared multiplier/adder computes C = A*B or C += A*B over eight cycles.
module block_mac_2x2 #(
    parameter int data_w = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_mac,
    input  logic              acc_en,
    input  logic [data_w-1:0] a_11,
    input  logic [data_w-1:0] a_12,
    input  logic [data_w-1:0] a_21,
    input  logic [data_w-1:0] a_22,
    input  logic [data_w-1:0] b_11,
    input  logic [data_w-1:0] b_12,
    input  logic [data_w-1:0] b_21,
    input  logic [data_w-1:0] b_22,
    output logic [data_w-1:0] c_11,
    output logic [data_w-1:0] c_12,
    output logic [data_w-1:0] c_21,
    output logic [data_w-1:0] c_22,
    output logic              done_mac,
    output logic              busy,
    output logic              ovf
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_nxt;
    logic [2:0] step;

    // Element index order for all three blocks: 0=x11, 1=x12, 2=x21, 3=x22
    logic [3:0][data_w-1:0] a_q, b_q, c_q;

    logic [data_w-1:0]   mul_a, mul_b, acc_in;
    logic [2*data_w-1:0] prod;
    logic [data_w:0]     sum;
    logic [1:0]          c_sel;

    // Step bits map directly to operands: A row=step[2], A col=step[0],
    // B row=step[0], B col=step[1], C element=step[2:1].
    always_comb begin
        mul_a  = a_q[{step[2], step[0]}];
        mul_b  = b_q[{step[0], step[1]}];
        c_sel  = step[2:1];
        acc_in = c_q[c_sel];
        prod   = {{data_w{1'b0}}, mul_a} * {{data_w{1'b0}}, mul_b};
        sum    = {1'b0, acc_in} + {1'b0, prod[data_w-1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mac)     state_nxt = MUL;
            MUL:     if (step == 3'd7)  state_nxt = DONE;
            DONE:    if (!start_mac)    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            ovf  <= 1'b0;
            step <= 3'd0;
        end else begin
            case (state)
                IDLE: if (start_mac) begin
                    a_q  <= {a_22, a_21, a_12, a_11};
                    b_q  <= {b_22, b_21, b_12, b_11};
                    if (!acc_en) c_q <= '0;
                    ovf  <= 1'b0;
                    step <= 3'd0;
                end
                MUL: begin
                    c_q[c_sel] <= sum[data_w-1:0];
                    if (prod[2*data_w-1:data_w] != '0 || sum[data_w]) ovf <= 1'b1;
                    step <= step + 3'd1;  // wraps to 0 on the step-7 edge
                end
                default: ;
            endcase
        end
    end

    assign c_11     = c_q[0];
    assign c_12     = c_q[1];
    assign c_21     = c_q[2];
    assign c_22     = c_q[3];
    assign done_mac = (state == DONE);
    assign busy     = (state == MUL) || (state == DONE);

endmodule

// File: tb/tb_block_mac_2x2.sv
// Directed bench for block_mac_2x2: vector table of whole operations plus
// hand-written handshake, operand-change and mid-operation reset sequences.
module tb_block_mac_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_mac, acc_en;
    logic [31:0] a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22;
    logic [31:0] c_11, c_12, c_21, c_22;
    logic        done_mac, busy, ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    block_mac_2x2 #(.data_w(32)) dut (
        .clk(clk), .rst(rst), .start_mac(start_mac), .acc_en(acc_en),
        .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
        .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
        .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
        .done_mac(done_mac), .busy(busy), .ovf(ovf)
    );

    typedef struct {
        logic        acc;
        logic [31:0] a[4];
        logic [31:0] b[4];
        logic [31:0] c[4];
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic acc,
                                input logic [31:0] a0, a1, a2, a3,
                                input logic [31:0] b0, b1, b2, b3,
                                input logic [31:0] c0, c1, c2, c3,
                                input logic o);
        vec_t v;
        v.acc = acc;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_c(input string tag, input logic [31:0] e0, e1, e2, e3);
        chk({tag, " c_11"}, c_11, e0);
        chk({tag, " c_12"}, c_12, e1);
        chk({tag, " c_21"}, c_21, e2);
        chk({tag, " c_22"}, c_22, e3);
    endtask

    // Called at a negedge with the block idle; capture happens at the next posedge.
    task automatic start_op(input vec_t v);
        acc_en = v.acc;
        a_11 = v.a[0]; a_12 = v.a[1]; a_21 = v.a[2]; a_22 = v.a[3];
        b_11 = v.b[0]; b_12 = v.b[1]; b_21 = v.b[2]; b_22 = v.b[3];
        start_mac = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges after the capture edge until done_mac is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done_mac && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic end_op(input string tag);
        start_mac = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done low after drop"}, {31'd0, done_mac}, 32'd0);
        chk({tag, " busy low after drop"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t basic;

    initial begin
        int n;
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        basic = mk(1'b0, 1, 2, 3, 4,  5, 6, 7, 8,  19, 22, 43, 50, 1'b0);
        vecs[0] = basic;
        vecs[1] = mk(1'b1, 1, 0, 0, 1,  1, 1, 1, 1,  20, 23, 44, 51, 1'b0);
        vecs[2] = mk(1'b0, 32'h0001_0000, 0, 0, 0,  32'h0001_0000, 0, 0, 0,  0, 0, 0, 0, 1'b1);
        vecs[3] = mk(1'b0, 2, 0, 0, 3,  4, 5, 6, 7,  8, 10, 18, 21, 1'b0);
        vecs[4] = mk(1'b1, ones, 0, 0, 0,  1, 0, 0, 0,  7, 10, 18, 21, 1'b1);
        vecs[5] = mk(1'b0, ones, ones, ones, ones,  1, 1, 1, 1,
                     32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1);

        rst = 1'b0; start_mac = 1'b0; acc_en = 1'b0;
        a_11 = 0; a_12 = 0; a_21 = 0; a_22 = 0;
        b_11 = 0; b_12 = 0; b_21 = 0; b_22 = 0;
        #3;
        chk_c("reset", 0, 0, 0, 0);
        chk("reset done", {31'd0, done_mac}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ovf",  {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_op(vecs[i]);
            chk({tag, " busy after capture"}, {31'd0, busy}, 32'd1);
            chk({tag, " done low in mul"}, {31'd0, done_mac}, 32'd0);
            wait_done(n);
            chk({tag, " latency"}, n, 32'd8);
            chk_c(tag, vecs[i].c[0], vecs[i].c[1], vecs[i].c[2], vecs[i].c[3]);
            chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, vecs[i].ovf});
            end_op(tag);
        end

        // Handshake: start_mac held 23 edges; DONE holds, no retrigger, c stable.
        begin
            int bad_done, bad_c;
            bad_done = 0; bad_c = 0;
            start_op(basic);
            for (int k = 1; k < 23; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done_mac !== (k >= 8)) bad_done++;
                if (k >= 8 && {c_11, c_12, c_21, c_22} !== {32'd19, 32'd22, 32'd43, 32'd50}) bad_c++;
            end
            chk("hold done pattern errors", bad_done, 0);
            chk("hold c stable errors", bad_c, 0);
            chk("hold busy in done", {31'd0, busy}, 32'd1);
            end_op("hold");
            chk_c("hold after drop", 19, 22, 43, 50);
        end

        // Operand change one cycle after capture has no effect.
        start_op(basic);
        a_11 = ones; a_12 = ones; a_21 = ones; a_22 = ones;
        b_11 = ones; b_12 = ones; b_21 = ones; b_22 = ones;
        acc_en = 1'b1;
        wait_done(n);
        chk("opchg latency", n, 32'd8);
        chk_c("opchg", 19, 22, 43, 50);
        chk("opchg ovf", {31'd0, ovf}, 32'd0);
        end_op("opchg");

        // start_mac dropped mid-MUL: completes, DONE lasts one cycle.
        start_op(vecs[3]);
        start_mac = 1'b0;
        wait_done(n);
        chk("early drop latency", n, 32'd8);
        chk_c("early drop", 8, 10, 18, 21);
        @(posedge clk);
        @(negedge clk);
        chk("early drop done one cycle", {31'd0, done_mac}, 32'd0);

        // Asynchronous reset with step 4 pending.
        start_op(basic);
        repeat (4) @(posedge clk);
        start_mac = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_c("midreset", 0, 0, 0, 0);
        chk("midreset done", {31'd0, done_mac}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post reset idle busy", {31'd0, busy}, 32'd0);
        chk("post reset idle done", {31'd0, done_mac}, 32'd0);
        chk_c("post reset", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
